// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latching interrupt sequencer with MASK/PENDING
// registers and a req/ack/eoi handshake that keeps one interrupt in service.
// Optional feature macro: IRQ_ROTATE_PRIO_EN (rotating priority instead of
// fixed lowest-index-wins priority).
`timescale 1ns/1ps

module interrupt_controller #(
    parameter int unsigned            NUM_IRQ  = 8,
    parameter int unsigned            VEC_W    = 10,
    parameter logic [VEC_W-1:0]       VEC_BASE = VEC_W'(10'h3F0)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               we,
    input  logic               addr,
    input  logic [NUM_IRQ-1:0] wdata,
    output logic [NUM_IRQ-1:0] rdata,
    output logic               int_req,
    output logic [VEC_W-1:0]   int_vec,
    output logic [2:0]         int_id,
    input  logic               int_ack,
    input  logic               int_eoi
);

    localparam int unsigned ID_W = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic               req_q, req_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [VEC_W-1:0]   vec_q, vec_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] eligible;
    logic [ID_W-1:0]    winner;
    logic               found;

`ifdef IRQ_ROTATE_PRIO_EN
    logic [ID_W-1:0]    last_served_q, last_served_d;
    logic [ID_W-1:0]    sel_idx;
`endif

    assign rise     = irq_in & ~irq_prev_q;
    assign eligible = pending_q & mask_q;

`ifdef IRQ_ROTATE_PRIO_EN
    // Rotating priority: first eligible line at or after last_served + 1.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            sel_idx = last_served_q + 3'd1 + ID_W'(i);
            if (!found && eligible[sel_idx]) begin
                winner = sel_idx;
                found  = 1'b1;
            end
        end
    end
`else
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!found && eligible[ID_W'(i)]) begin
                winner = ID_W'(i);
                found  = 1'b1;
            end
        end
    end
`endif

    // Register file updates and handshake sequencing.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        req_d   = req_q;
        id_d    = id_q;
        vec_d   = vec_q;
        clr     = '0;
`ifdef IRQ_ROTATE_PRIO_EN
        last_served_d = last_served_q;
`endif

        if (we && !addr) begin
            mask_d = wdata;
        end
        if (we && addr) begin
            clr = wdata;
        end

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    id_d    = winner;
                    vec_d   = VEC_BASE | VEC_W'(winner);
                end
            end
            S_REQ: begin
                // Committed request: only the ack moves us on.
                if (int_ack) begin
                    clr[id_q] = 1'b1;
                    req_d     = 1'b0;
                    state_d   = S_SERVICE;
`ifdef IRQ_ROTATE_PRIO_EN
                    last_served_d = id_q;
`endif
                end
            end
            S_SERVICE: begin
                if (int_eoi) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // A new rise overrides any clear of the same bit.
        pending_d = (pending_q & ~clr) | rise;
    end

    // State and register flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            irq_prev_q <= '0;
            mask_q     <= '0;
            pending_q  <= '0;
            req_q      <= 1'b0;
            id_q       <= '0;
            vec_q      <= VEC_BASE;
`ifdef IRQ_ROTATE_PRIO_EN
            last_served_q <= 3'd7;
`endif
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_in;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            req_q      <= req_d;
            id_q       <= id_d;
            vec_q      <= vec_d;
`ifdef IRQ_ROTATE_PRIO_EN
            last_served_q <= last_served_d;
`endif
        end
    end

    // Zero-latency register readback.
    always_comb begin
        rdata = addr ? pending_q : mask_q;
    end

    assign int_req = req_q;
    assign int_id  = id_q;
    assign int_vec = vec_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: directed scenarios plus randomized
// mask/edge patterns; expected service order comes from a set-based model.
`timescale 1ns/1ps

module tb_interrupt_controller;

`ifdef IRQ_ROTATE_PRIO_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] irq_in;
    logic       we;
    logic       addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       int_req;
    logic [9:0] int_vec;
    logic [2:0] int_id;
    logic       int_ack;
    logic       int_eoi;

    interrupt_controller dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .int_req (int_req),
        .int_vec (int_vec),
        .int_id  (int_id),
        .int_ack (int_ack),
        .int_eoi (int_eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    // Reference model state: pending set, mask, last served line.
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    int         m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Next line to be served out of an eligible set.
    function automatic int pick(input logic [7:0] elig, input int last);
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = ROT ? (last + 1 + i) % 8 : i;
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    // Monitor: every new request is popped from the scoreboard and compared.
    initial begin : monitor
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (int_req && !req_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got id %0d expected no request", int_id);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("req_id", 32'(int_id), 32'(e));
                    check("req_vec", 32'(int_vec), 32'(32'h3F0 | e));
                end
            end
            req_prev = int_req;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input string name, input logic a, input logic [7:0] exp);
        addr = a;
        #1;
        check(name, 32'(rdata), 32'(exp));
    endtask

    task automatic pulse(input logic [7:0] p);
        irq_in = p;
        tick();
        irq_in = 8'h00;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        m_pend = 8'h00;
        m_mask = 8'h00;
        m_last = 7;
    endtask

    // CPU side: wait for a request, ack, optionally raise edges mid-service, eoi.
    task automatic serve_one(input logic [7:0] mid);
        int cnt;
        cnt = 0;
        while (!int_req && cnt < 32) begin
            tick();
            cnt++;
        end
        if (!int_req) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: got int_req 0 expected 1 within 32 cycles");
            exp_q.delete();
            return;
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("ack_drop", 32'(int_req), 32'd0);
        if (mid != 8'h00) begin
            pulse(mid);
            m_pend = m_pend | mid;
        end
        repeat ($urandom_range(0, 3)) tick();
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
    endtask

    // Serve everything the model says is eligible, in model order.
    task automatic drain(input bit allow_mid);
        for (int guard = 0; guard < 40; guard++) begin
            int id;
            logic [7:0] mid;
            if ((m_pend & m_mask) == 8'h00) break;
            id = pick(m_pend & m_mask, m_last);
            exp_q.push_back(id);
            m_pend[id] = 1'b0;
            m_last     = id;
            mid = (allow_mid && $urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            serve_one(mid);
        end
    endtask

    initial begin : stimulus
        logic [7:0] r_mask, r_pat, r_clr;
        int cnt;

        reset   = 1'b0;
        irq_in  = 8'hFF;
        we      = 1'b0;
        addr    = 1'b0;
        wdata   = 8'h00;
        int_ack = 1'b0;
        int_eoi = 1'b0;
        m_pend  = 8'h00;
        m_mask  = 8'h00;
        m_last  = 7;

        // Reset values with all lines high.
        repeat (3) tick();
        check("rst_req", 32'(int_req), 32'd0);
        check("rst_vec", 32'(int_vec), 32'h3F0);
        check("rst_id", 32'(int_id), 32'd0);
        rd("rst_mask", 1'b0, 8'h00);
        rd("rst_pend", 1'b1, 8'h00);
        tick();
        reset = 1'b1;
        tick();
        rd("pend_after_rst", 1'b1, 8'hFF);
        irq_in = 8'h00;
        wr(1'b1, 8'hFF);
        rd("pend_cleared", 1'b1, 8'h00);

        // Basic handshake on line 2 with cycle-exact timing.
        wr(1'b0, 8'h04);
        m_mask = 8'h04;
        exp_q.push_back(2);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        rd("basic_pend", 1'b1, 8'h04);
        check("basic_req_latency", 32'(int_req), 32'd0);
        tick();
        check("basic_req", 32'(int_req), 32'd1);
        check("basic_id", 32'(int_id), 32'd2);
        check("basic_vec", 32'(int_vec), 32'h3F2);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("basic_ack_req", 32'(int_req), 32'd0);
        check("basic_ack_id", 32'(int_id), 32'd2);
        rd("basic_ack_pend", 1'b1, 8'h00);
        m_last = 2;
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        check("basic_eoi_req", 32'(int_req), 32'd0);

        // Masked source stays pending until enabled.
        pulse(8'h20);
        m_pend = m_pend | 8'h20;
        rd("masked_pend", 1'b1, 8'h20);
        repeat (4) begin
            tick();
            check("masked_noreq", 32'(int_req), 32'd0);
        end
        wr(1'b0, 8'h24);
        m_mask = 8'h24;
        drain(1'b0);
        rd("masked_done", 1'b1, 8'h00);

        // Simultaneous lines 1 and 6 from a fresh reset.
        apply_reset();
        wr(1'b0, 8'hFF);
        m_mask = 8'hFF;
        pulse(8'h42);
        m_pend = m_pend | 8'h42;
        drain(1'b0);

        // Serve line 1, re-pend 1 and 6 during its service, then drain.
        apply_reset();
        wr(1'b0, 8'hFF);
        m_mask = 8'hFF;
        pulse(8'h42);
        m_pend = m_pend | 8'h42;
        exp_q.push_back(pick(m_pend & m_mask, m_last));
        m_pend[1] = 1'b0;
        m_last    = 1;
        serve_one(8'h42);
        drain(1'b0);
        rd("simul_done", 1'b1, 8'h00);

        // Set beats clear on the same bit.
        wr(1'b0, 8'h00);
        m_mask = 8'h00;
        irq_in = 8'h08;
        we     = 1'b1;
        addr   = 1'b1;
        wdata  = 8'h08;
        tick();
        we     = 1'b0;
        irq_in = 8'h00;
        m_pend = m_pend | 8'h08;
        rd("set_beats_clr", 1'b1, 8'h08);
        wr(1'b1, 8'hFF);
        m_pend = 8'h00;
        rd("sbc_cleared", 1'b1, 8'h00);

        // Randomized masks and edge patterns.
        for (int it = 0; it < 40; it++) begin
            r_mask = 8'($urandom);
            wr(1'b0, r_mask);
            m_mask = r_mask;
            r_pat = 8'($urandom);
            pulse(r_pat);
            m_pend = m_pend | r_pat;
            drain(1'b1);
            rd("rnd_pend", 1'b1, m_pend);
            r_clr = 8'($urandom);
            wr(1'b1, r_clr);
            m_pend = m_pend & ~r_clr;
            rd("rnd_clr", 1'b1, m_pend);
            wr(1'b1, 8'hFF);
            m_pend = 8'h00;
        end

        // Reset asserted mid-request drops int_req asynchronously.
        wr(1'b0, 8'h04);
        m_mask = 8'h04;
        exp_q.push_back(pick(8'h04, m_last));
        irq_in = 8'h04;
        cnt = 0;
        while (!int_req && cnt < 32) begin
            tick();
            cnt++;
        end
        check("midrst_req_seen", 32'(int_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_req", 32'(int_req), 32'd0);
        check("midrst_vec", 32'(int_vec), 32'h3F0);
        rd("midrst_mask", 1'b0, 8'h00);
        tick();
        reset = 1'b1;
        tick();
        rd("midrst_pend", 1'b1, 8'h04);
        irq_in = 8'h00;
        m_pend = 8'h04;
        m_mask = 8'h00;
        m_last = 7;
        wr(1'b1, 8'hFF);
        m_pend = 8'h00;

        repeat (5) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Sequencer between the interrupt sources (timer, I/O manager) and the single-cycle CPU. Latches rising edges on the 8-bit interrupt bus and masks them through a small register file written over the I/O bus. It then selects one source by priority and runs a request/acknowledge/end-of-interrupt handshake with the CPU, so exactly one interrupt is in service at a time.

## Interface
- `NUM_IRQ`, default 8: number of request lines; fixed at 8, and the id field is 3 bits.
- `VEC_W`, default 10: width of the vector output.
- `VEC_BASE`, default 10'h3F0: vector base; bits [2:0] must be 0.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_in`  in  8  raw request lines, synchronous to `clk`.
- `we`  in  1  register write strobe.
- `addr`  in  1  register select: 0 = MASK, 1 = PENDING (a write clears bits).
- `wdata`  in  8  write data.
- `rdata`  out  8  read data; combinational from `addr`.
- `int_req`  out  1  interrupt request to the CPU.
- `int_vec`  out  VEC_W  handler address, equal to VEC_BASE | id.
- `int_id`  out  3  id of the requested or in-service source.
- `int_ack`  in  1  CPU accepts the request; single-cycle pulse.
- `int_eoi`  in  1  CPU handler finished; single-cycle pulse.

## Operation
- **Edge detection:**
  - `irq_prev` <= `irq_in` every cycle.
  - `rise` = `irq_in & ~irq_prev`.
  - `pending[i]` is set on `rise[i]`.
  - `irq_prev` resets to 0, so a line already high at reset release counts as one edge.
- **MASK register:** bit = 1 enables the source; reset value 8'h00. Writing `addr`=0 loads `wdata`.
- **PENDING register:**
  - Writing `addr`=1 clears the bits where `wdata` = 1.
  - When a set and a clear hit the same bit in the same cycle, the set wins.
- **Eligibility:** `eligible` = `pending & mask`.
- **Selection:** fixed priority, where the lowest index wins (see Configuration for the rotating alternative).
- **IDLE state:**
  - `int_req` = 0.
  - If `eligible` != 0, capture the winner into `cur_id`, then go to REQ.
- **REQ state:**
  - `int_req` = 1; `int_id`/`int_vec` are stable.
  - The request is committed: it is not withdrawn if the source is masked or cleared meanwhile.
  - On `int_ack`: clear `pending[cur_id]` (unless a new rise arrives that cycle), drop `int_req`, go to SERVICE.
- **SERVICE state:**
  - `int_req` = 0 and `int_id` holds.
  - New edges keep accumulating in PENDING.
  - On `int_eoi`, go to IDLE.
- **Ignored handshakes:** `int_ack` outside REQ and `int_eoi` outside SERVICE have no effect.
- **Reset values:** `int_req` = 0, `int_id` = 0, `int_vec` = VEC_BASE, MASK = PENDING = 0, state IDLE.
- **Reset mid-operation:** asserting reset aborts any REQ or SERVICE immediately and asynchronously.

## Timing
- Rise sampled at edge k: PENDING bit is visible after edge k.
- If enabled, `int_req` goes high after edge k+1: a 2-edge latency from the sampled rise.
- `int_ack` sampled at edge m: `int_req` is low and the pending bit cleared after edge m.
- `int_eoi` sampled at edge p: state is IDLE after p; the earliest next `int_req` is after edge p+1.
- `int_vec` and `int_id` change only on the IDLE->REQ transition.
- `rdata` follows register state after the same edge; there is no read latency.
- A MASK write at edge w affects eligibility from edge w+1.

## Configuration
- Macro: `IRQ_ROTATE_PRIO_EN`.
- **Defined:** rotating priority.
  - The search starts at (`last_served` + 1) mod 8.
  - `last_served` updates on `int_ack` and resets to 7, so line 0 is first after reset.
- **Undefined:** fixed priority (line 0 highest), and no `last_served` register exists.

## Test plan
- **Reset:** hold `reset`=0 with `irq_in`=8'hFF. Required: `int_req`=0, `int_vec`=10'h3F0, MASK and PENDING read 8'h00. After release, PENDING reads 8'hFF.
- **Basic handshake:**
  - Write MASK=8'h04, then pulse `irq_in[2]`.
  - Required: PENDING=8'h04, then `int_req`=1 one edge later with `int_vec`=10'h3F2 and `int_id`=2.
  - Then `int_ack`: `int_req`=0 and PENDING=8'h00 next edge.
  - Then `int_eoi`: state returns to IDLE.
- **Masked source:**
  - With MASK=8'h04, edge on `irq_in[5]`: PENDING=8'h20 and `int_req` stays 0.
  - Write MASK=8'h24: `int_req`=1 with `int_id`=5.
- **Simultaneous sources:** MASK=8'hFF, edges on lines 1 and 6 in the same cycle.
  - Fixed priority: line 1 is served, then line 6 after EOI.
  - With `IRQ_ROTATE_PRIO_EN`: after line 1 is served, re-pend lines 1 and 6 together; line 6 is served before line 1.
- **Set beats clear:** write `addr`=1, `wdata`=8'h08 in the same cycle as a rise on line 3. Required: PENDING bit 3 reads 1.
- **Reset mid-request:** assert `reset` while `int_req`=1. Required: `int_req`=0 without waiting for a clock edge. After release, with `irq_in[2]` held high, PENDING bit 2 sets again.
